ped_request_latch: RTL and testbench
====================================

PED_REQUEST_LATCH -- requirements
Module: ped_request_latch

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: number of consecutive stable synchronized samples required before btn_clean changes (legal range 1..255).
REQ-002 Parameter HOLDOFF_CYCLES, default 8: number of lockout cycles after each acknowledged request when the holdoff feature is compiled in (legal range 1..255).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 btn_raw  input  1  asynchronous, bouncing pedestrian push-button level (1 = pressed).
REQ-006 req_ack  input  1  one-cycle pulse from the traffic controller meaning "request served".
REQ-007 btn_clean  output  1  synchronized, debounced button level.
REQ-008 req_pending  output  1  level; a captured request awaits service.
REQ-009 req_edge  output  1  one-cycle pulse marking capture of a new request.
REQ-010 served_count  output  8  count of acknowledged requests.

Function
REQ-011 btn_raw SHALL pass through a two-flop synchronizer; no other logic SHALL sample btn_raw.
REQ-012 Debounce counter behaviour:
- The counter SHALL increment on each cycle in which the synchronized value differs from btn_clean.
- The counter SHALL clear on any cycle in which the synchronized value equals btn_clean.
- btn_clean SHALL toggle, and the counter SHALL clear, on the edge where the count reaches DEBOUNCE_CYCLES.
REQ-013 Debounce latency: with btn_raw held stable at a new value from clock edge k, btn_clean SHALL take that value at edge k+1+DEBOUNCE_CYCLES.
REQ-014 The block SHALL implement a state machine with states IDLE, PENDING and HOLDOFF; HOLDOFF exists only per REQ-024.
REQ-015 IDLE -> PENDING on a btn_clean rising edge (btn_clean = 1 with its previous value 0):
- req_edge SHALL be 1 for exactly the first cycle in PENDING.
- req_pending SHALL be 1 in every cycle spent in PENDING.
REQ-016 In IDLE, req_ack SHALL be ignored: no state change, no count change.
REQ-017 In PENDING, further btn_clean edges SHALL be ignored; there is no request queueing.
REQ-018 On req_ack in PENDING:
- served_count SHALL increment by 1, wrapping 255 -> 0.
- req_pending SHALL fall on the next edge.
- Next state SHALL be IDLE, or HOLDOFF per REQ-024.
REQ-019 Simultaneous req_ack and btn_clean rising edge while in PENDING: the ack SHALL be processed and the new edge SHALL be dropped.
REQ-020 Simultaneous btn_clean rising edge and req_ack while in IDLE: the request SHALL be captured and the ack ignored.
REQ-021 Captures SHALL be edge-based only: a button still held when the machine returns to IDLE SHALL NOT create a new request.

Reset
REQ-022 While reset = 0, regardless of clk:
- Synchronizer flops, debounce counter, btn_clean, req_pending, req_edge and served_count SHALL be 0.
- State SHALL be IDLE.
REQ-023 Reset asserted mid-debounce, in PENDING or in HOLDOFF SHALL discard all in-flight state; after reset release, the first capture SHALL require a full synchronize-plus-debounce sequence.

Configuration
REQ-024 Macro PED_REQ_HOLDOFF_EN:
- When defined, an acknowledged request SHALL enter HOLDOFF for exactly HOLDOFF_CYCLES cycles, during which btn_clean edges are dropped and req_pending = 0, then return to IDLE.
- When undefined, ack SHALL go directly to IDLE, no holdoff counter SHALL be synthesized, and HOLDOFF_CYCLES SHALL have no effect.

Verification
REQ-025 Clean press, DEBOUNCE_CYCLES = 4: btn_raw 0 -> 1 sampled at edge 10 -> btn_clean = 1 at edge 15; req_pending = 1 and a single req_edge pulse at edge 16.
REQ-026 Bounce rejection: btn_raw toggling every 2 cycles for 20 cycles, then 0 -> btn_clean, req_pending and req_edge remain 0 throughout.
REQ-027 Ack handling:
- req_ack pulse in PENDING -> req_pending = 0 next edge and served_count 0 -> 1.
- After 256 such acks served_count returns to 0.
- Ack while IDLE -> served_count unchanged.
REQ-028 Simultaneity: ack coincident with a new btn_clean rising edge in PENDING -> IDLE, edge not captured; held button -> no re-capture until release and a new press.
REQ-029 Holdoff, macro defined, HOLDOFF_CYCLES = 8: new press debounced 3 cycles after ack -> dropped; press debounced 10 cycles after ack -> captured. Macro undefined: the 3-cycle case is captured.
REQ-030 Reset: reset = 0 asserted while PENDING with served_count = 5 -> all outputs 0 asynchronously, before the next clk edge; after release a press follows the REQ-025 timing.

Source files
------------

// File: rtl/ped_request_latch.sv
// Pedestrian button front end: synchronizes and debounces btn_raw and latches one request until acknowledged.
// Define PED_REQ_HOLDOFF_EN to add a HOLDOFF_CYCLES lockout after every acknowledged request.
module ped_request_latch #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned HOLDOFF_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_raw,
    input  logic       req_ack,
    output logic       btn_clean,
    output logic       req_pending,
    output logic       req_edge,
    output logic [7:0] served_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1
`ifdef PED_REQ_HOLDOFF_EN
        ,HOLDOFF = 2'd2
`endif
    } state_e;

    localparam logic [8:0] DbTarget = 9'(DEBOUNCE_CYCLES);

    logic       sync1_q;
    logic       sync2_q;
    logic [7:0] db_cnt_q;
    logic [7:0] db_cnt_d;
    logic       btn_clean_q;
    logic       btn_clean_d;
    logic       clean_prev_q;
    logic       clean_rise;
    state_e     state_q;
    state_e     state_d;
    logic       req_edge_q;
    logic       req_edge_d;
    logic [7:0] served_q;
    logic [7:0] served_d;

`ifdef PED_REQ_HOLDOFF_EN
    localparam logic [7:0] HoldLast = 8'(HOLDOFF_CYCLES - 1);
    logic [7:0] hold_cnt_q;
    logic [7:0] hold_cnt_d;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            db_cnt_q     <= '0;
            btn_clean_q  <= 1'b0;
            clean_prev_q <= 1'b0;
        end else begin
            sync1_q      <= btn_raw;
            sync2_q      <= sync1_q;
            db_cnt_q     <= db_cnt_d;
            btn_clean_q  <= btn_clean_d;
            clean_prev_q <= btn_clean_q;
        end
    end

    // Only an unbroken run of DEBOUNCE_CYCLES disagreeing samples flips the clean level.
    always_comb begin
        db_cnt_d    = '0;
        btn_clean_d = btn_clean_q;
        if (sync2_q != btn_clean_q) begin
            if (({1'b0, db_cnt_q} + 9'd1) == DbTarget) begin
                btn_clean_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 8'd1;
            end
        end
    end

    assign clean_rise = btn_clean_q & ~clean_prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            req_edge_q <= 1'b0;
            served_q   <= '0;
`ifdef PED_REQ_HOLDOFF_EN
            hold_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            req_edge_q <= req_edge_d;
            served_q   <= served_d;
`ifdef PED_REQ_HOLDOFF_EN
            hold_cnt_q <= hold_cnt_d;
`endif
        end
    end

    // Captures are edge-based, so a button still held after service never re-triggers.
    always_comb begin
        state_d    = state_q;
        req_edge_d = 1'b0;
        served_d   = served_q;
`ifdef PED_REQ_HOLDOFF_EN
        hold_cnt_d = hold_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (clean_rise) begin
                    state_d    = PENDING;
                    req_edge_d = 1'b1;
                end
            end
            PENDING: begin
                if (req_ack) begin
                    served_d = served_q + 8'd1;
`ifdef PED_REQ_HOLDOFF_EN
                    state_d    = HOLDOFF;
                    hold_cnt_d = '0;
`else
                    state_d    = IDLE;
`endif
                end
            end
`ifdef PED_REQ_HOLDOFF_EN
            HOLDOFF: begin
                if (hold_cnt_q == HoldLast) begin
                    state_d = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        req_pending = 1'b0;
        req_edge    = 1'b0;
        case (state_q)
            PENDING: begin
                req_pending = 1'b1;
                req_edge    = req_edge_q;
            end
            default: begin
                req_pending = 1'b0;
                req_edge    = 1'b0;
            end
        endcase
    end

    assign btn_clean    = btn_clean_q;
    assign served_count = served_q;

endmodule

// File: tb/tb_ped_request_latch.sv
// Self-checking bench for ped_request_latch: vector table, corner-case sequences and randomized traffic
// compared against a behavioural model (honours PED_REQ_HOLDOFF_EN when defined).
module tb_ped_request_latch;

    localparam int DEB  = 4;
    localparam int HOLD = 8;

    logic       clk;
    logic       reset;
    logic       btn_raw;
    logic       req_ack;
    logic       btn_clean;
    logic       req_pending;
    logic       req_edge;
    logic [7:0] served_count;

    int testsRun;
    int testsFailed;

    // Behavioural model state, advanced once per rising edge by the driving process.
    bit         mS1;
    bit         mS2;
    bit         mHist[$];
    bit         mClean;
    bit         mPrev;
    bit         mPending;
    bit         mEdge;
    int         mHold;
    logic [7:0] mServed;

    typedef struct {
        logic       raw;
        logic       ack;
        int         n;
        logic       eClean;
        logic       ePend;
        logic       eEdge;
        logic [7:0] eServed;
    } vec_t;

    vec_t tbl[12];

    ped_request_latch #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLDOFF_CYCLES (HOLD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .req_ack     (req_ack),
        .btn_clean   (btn_clean),
        .req_pending (req_pending),
        .req_edge    (req_edge),
        .served_count(served_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic modelReset();
        mS1      = 1'b0;
        mS2      = 1'b0;
        mHist.delete();
        mClean   = 1'b0;
        mPrev    = 1'b0;
        mPending = 1'b0;
        mEdge    = 1'b0;
        mHold    = 0;
        mServed  = 8'd0;
    endtask

    // Clean level flips once the last DEB synchronized samples all disagree with it.
    task automatic modelStep();
        bit newClean;
        bit allDiffer;
        bit rise;
        newClean = mClean;
        mHist.push_back(mS2);
        if (mHist.size() > DEB) void'(mHist.pop_front());
        allDiffer = (mHist.size() == DEB);
        for (int i = 0; i < mHist.size(); i++) begin
            if (mHist[i] == mClean) allDiffer = 1'b0;
        end
        if (allDiffer) begin
            newClean = ~mClean;
            mHist.delete();
        end
        rise  = mClean && !mPrev;
        mEdge = 1'b0;
        if (mHold > 0) begin
            mHold = mHold - 1;
        end else if (mPending) begin
            if (req_ack) begin
                mServed  = mServed + 8'd1;
                mPending = 1'b0;
`ifdef PED_REQ_HOLDOFF_EN
                mHold    = HOLD;
`endif
            end
        end else if (rise) begin
            mPending = 1'b1;
            mEdge    = 1'b1;
        end
        mPrev  = mClean;
        mClean = newClean;
        mS2    = mS1;
        mS1    = btn_raw;
    endtask

    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            modelStep();
            @(negedge clk);
        end
    endtask

    task automatic applyStimulus(input logic raw, input logic ack, input int n);
        btn_raw = raw;
        req_ack = ack;
        cycle(n);
    endtask

    task automatic applyReset();
        reset   = 1'b0;
        btn_raw = 1'b0;
        req_ack = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic checkOutput(input string name, input logic eClean, input logic ePend,
                               input logic eEdge, input logic [7:0] eServed);
        testsRun++;
        if (btn_clean !== eClean || req_pending !== ePend || req_edge !== eEdge || served_count !== eServed) begin
            testsFailed++;
            $display("[TB] FAIL %s: got clean=%0b pend=%0b edge=%0b count=%0d, expected clean=%0b pend=%0b edge=%0b count=%0d",
                     name, btn_clean, req_pending, req_edge, served_count, eClean, ePend, eEdge, eServed);
        end
    endtask

    task automatic checkModel(input string name);
        checkOutput(name, mClean, mPending, mEdge, mServed);
    endtask

    task automatic pressAndAck();
        applyStimulus(1'b1, 1'b0, 7);
        applyStimulus(1'b1, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 10);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;

        tbl[0]  = '{1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[1]  = '{1'b1, 1'b0, 5, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[2]  = '{1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[3]  = '{1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b1, 8'd0};
        tbl[4]  = '{1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0, 8'd0};
        tbl[5]  = '{1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0, 8'd1};
        tbl[6]  = '{1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b0, 8'd1};
        tbl[7]  = '{1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0, 8'd1};
        tbl[8]  = '{1'b0, 1'b0, 5, 1'b1, 1'b0, 1'b0, 8'd1};
        tbl[9]  = '{1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'd1};
        tbl[10] = '{1'b1, 1'b0, 6, 1'b1, 1'b0, 1'b0, 8'd1};
        tbl[11] = '{1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b1, 8'd1};

        applyReset();
        checkOutput("reset_state", 1'b0, 1'b0, 1'b0, 8'd0);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(tbl[i].raw, tbl[i].ack, tbl[i].n);
            checkOutput($sformatf("vec%0d", i), tbl[i].eClean, tbl[i].ePend, tbl[i].eEdge, tbl[i].eServed);
        end

        // Ack coincides with a fresh clean rise while pending: ack wins, edge is lost.
        applyStimulus(1'b0, 1'b0, 6);
        checkOutput("pend_release", 1'b0, 1'b1, 1'b0, 8'd1);
        applyStimulus(1'b1, 1'b0, 6);
        applyStimulus(1'b1, 1'b1, 1);
        checkOutput("ack_with_rise", 1'b1, 1'b0, 1'b0, 8'd2);
        applyStimulus(1'b1, 1'b0, 20);
        checkOutput("held_no_recapture", 1'b1, 1'b0, 1'b0, 8'd2);
        checkModel("held_model");
        applyStimulus(1'b0, 1'b0, 7);
        applyStimulus(1'b1, 1'b0, 7);
        checkOutput("new_press_after_release", 1'b1, 1'b1, 1'b1, 8'd2);

        // Rise in IDLE together with an ack: captured, count unchanged.
        applyStimulus(1'b0, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 10);
        applyStimulus(1'b1, 1'b0, 6);
        applyStimulus(1'b1, 1'b1, 1);
        checkOutput("idle_rise_with_ack", 1'b1, 1'b1, 1'b1, 8'd3);

        // Bounce shorter than the debounce window never reaches the outputs.
        applyReset();
        for (int i = 0; i < 30; i++) begin
            applyStimulus((i < 20) ? logic'(((i / 2) % 2) == 0) : 1'b0, 1'b0, 1);
            checkOutput($sformatf("bounce%0d", i), 1'b0, 1'b0, 1'b0, 8'd0);
        end

        // served_count wraps after 256 acks.
        applyReset();
        for (int i = 0; i < 256; i++) begin
            pressAndAck();
            if (i == 0) checkOutput("first_ack", 1'b0, 1'b0, 1'b0, 8'd1);
            checkModel($sformatf("wrap%0d", i));
        end
        checkOutput("wrap_to_zero", 1'b0, 1'b0, 1'b0, 8'd0);

        // Press debounced 3 cycles after ack.
        applyReset();
        applyStimulus(1'b1, 1'b0, 7);
        applyStimulus(1'b0, 1'b0, 6);
        applyStimulus(1'b1, 1'b0, 2);
        applyStimulus(1'b1, 1'b1, 1);
        applyStimulus(1'b1, 1'b0, 4);
`ifdef PED_REQ_HOLDOFF_EN
        checkOutput("press_3_after_ack", 1'b1, 1'b0, 1'b0, 8'd1);
`else
        checkOutput("press_3_after_ack", 1'b1, 1'b1, 1'b1, 8'd1);
`endif
        checkModel("press_3_model");

        // Press debounced 10 cycles after ack.
        applyReset();
        applyStimulus(1'b1, 1'b0, 7);
        applyStimulus(1'b0, 1'b0, 6);
        applyStimulus(1'b0, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 4);
        applyStimulus(1'b1, 1'b0, 7);
        checkOutput("press_10_after_ack", 1'b1, 1'b1, 1'b1, 8'd1);

        // Asynchronous reset while pending with five requests served.
        applyReset();
        for (int i = 0; i < 5; i++) pressAndAck();
        applyStimulus(1'b1, 1'b0, 7);
        checkOutput("pending_before_reset", 1'b1, 1'b1, 1'b1, 8'd5);
        #2;
        reset   = 1'b0;
        btn_raw = 1'b0;
        #1;
        checkOutput("async_reset", 1'b0, 1'b0, 1'b0, 8'd0);
        modelReset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 5);
        checkOutput("post_reset_clean_low", 1'b0, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("post_reset_clean_high", 1'b1, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("post_reset_capture", 1'b1, 1'b1, 1'b1, 8'd0);

        // Randomized traffic against the model.
        applyReset();
        begin
            int  holdLeft;
            logic raw;
            holdLeft = 0;
            raw      = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if (holdLeft == 0) begin
                    raw      = logic'($urandom_range(0, 1));
                    holdLeft = $urandom_range(1, 12);
                end
                holdLeft--;
                applyStimulus(raw, logic'($urandom_range(0, 3) == 0), 1);
                checkModel($sformatf("rand%0d", i));
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
